// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program counter: jump condition codes,
// the run/halt state encoding and the condition evaluator.
package sap_pkg;

    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_CARRY  = 2'b01;
    localparam logic [1:0] JC_ZERO   = 2'b10;
    localparam logic [1:0] JC_NEVER  = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    // Flags are only meaningful in the cycle the jump is requested,
    // so the caller gates this with jump_en.
    function automatic logic jump_cond_met(input logic [1:0] cond,
                                           input logic       carry,
                                           input logic       zero);
        logic met;
        case (cond)
            JC_ALWAYS: met = 1'b1;
            JC_CARRY:  met = carry;
            JC_ZERO:   met = zero;
            default:   met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/sap_load_register.sv
// Generic WIDTH-bit register with load enable and asynchronous active-low
// reset to a parameterised value.
module sap_load_register #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RESET_Q = RESET_VALUE[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_Q;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/sap_program_counter.sv
// SAP CPU program counter: increment, conditional jump from the bus, bus
// drive and a sticky HALTED state that only reset clears.
module sap_program_counter
    import sap_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             jump_en,
    input  logic [1:0]       jump_cond,
    input  logic             flag_carry,
    input  logic             flag_zero,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             out_en,
    input  logic             halt,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] pc_value,
    output logic             halted,
    output logic             wrap
);

    pc_state_t        state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic             pc_load;
    logic             wrap_q, wrap_next;
    logic             take_jump;

    sap_load_register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_pc_reg (
        .clk  (clk),
        .reset(reset),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_next;
            wrap_q <= wrap_next;
        end
    end

    assign take_jump = jump_en && jump_cond_met(jump_cond, flag_carry, flag_zero);

    // Priority in RUN is halt, then jump, then count; HALTED ignores all strobes.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        pc_load    = 1'b0;
        wrap_next  = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (take_jump) begin
                    pc_next = bus_in;
                    pc_load = 1'b1;
                end else if (count_en) begin
                    pc_next   = pc + WIDTH'(1);
                    pc_load   = 1'b1;
                    wrap_next = (pc == {WIDTH{1'b1}});
                end
            end
            default: begin
                state_next = ST_HALTED;
            end
        endcase
    end

    always_comb begin
        pc_value = pc;
        halted   = (state == ST_HALTED);
        wrap     = wrap_q;
        bus_out  = out_en ? pc : '0;
    end

endmodule

// File: tb/tb_sap_program_counter.sv
// Scoreboard bench for sap_program_counter: directed steps push the
// hand-computed expected outputs, a monitor pops and compares each cycle.
module tb_sap_program_counter;
    import sap_pkg::*;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic             halted;
        logic             wrap;
        logic [WIDTH-1:0] bus;
        string            name;
    } expect_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             count_en, jump_en, flag_carry, flag_zero, out_en, halt;
    logic [1:0]       jump_cond;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out, pc_value;
    logic             halted, wrap;

    expect_t scoreboard[$];
    int total = 0;
    int bad   = 0;

    sap_program_counter #(.WIDTH(WIDTH), .RESET_VALUE(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_en  (count_en),
        .jump_en   (jump_en),
        .jump_cond (jump_cond),
        .flag_carry(flag_carry),
        .flag_zero (flag_zero),
        .bus_in    (bus_in),
        .out_en    (out_en),
        .halt      (halt),
        .bus_out   (bus_out),
        .pc_value  (pc_value),
        .halted    (halted),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] got_pc,
                               input logic got_halted, input logic got_wrap,
                               input logic [WIDTH-1:0] got_bus, input expect_t e);
        total++;
        if (got_pc !== e.pc || got_halted !== e.halted || got_wrap !== e.wrap || got_bus !== e.bus) begin
            bad++;
            $display("[TB] FAIL %s: got pc=%0d halted=%0b wrap=%0b bus=%0d, want pc=%0d halted=%0b wrap=%0b bus=%0d",
                     name, got_pc, got_halted, got_wrap, got_bus, e.pc, e.halted, e.wrap, e.bus);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput(e.name, pc_value, halted, wrap, bus_out, e);
            end
        end
    end

    // Drive one cycle of strobes, then queue what the outputs must be after the edge.
    task automatic applyStimulus(input string name, input logic cnt, input logic jmp,
                                 input logic [1:0] jc, input logic cy, input logic zf,
                                 input logic [WIDTH-1:0] target, input logic oe, input logic hlt,
                                 input logic [WIDTH-1:0] exp_pc, input logic exp_halted,
                                 input logic exp_wrap);
        expect_t e;
        count_en   = cnt;
        jump_en    = jmp;
        jump_cond  = jc;
        flag_carry = cy;
        flag_zero  = zf;
        bus_in     = target;
        out_en     = oe;
        halt       = hlt;
        @(posedge clk);
        e.pc     = exp_pc;
        e.halted = exp_halted;
        e.wrap   = exp_wrap;
        e.bus    = oe ? exp_pc : '0;
        e.name   = name;
        scoreboard.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic directCheck(input string name, input logic [WIDTH-1:0] exp_pc,
                               input logic exp_halted, input logic exp_wrap,
                               input logic [WIDTH-1:0] exp_bus);
        expect_t e;
        e.pc     = exp_pc;
        e.halted = exp_halted;
        e.wrap   = exp_wrap;
        e.bus    = exp_bus;
        e.name   = name;
        checkOutput(name, pc_value, halted, wrap, bus_out, e);
    endtask

    task automatic asyncResetPulse(input string name);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 directCheck(name, 4'd0, 1'b0, 1'b0, out_en ? 4'd0 : 4'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; count_en = 0; jump_en = 0; jump_cond = JC_NEVER;
        flag_carry = 0; flag_zero = 0; bus_in = '0; out_en = 0; halt = 0;
        #3 directCheck("reset_state", 4'd0, 1'b0, 1'b0, 4'd0);
        out_en = 1'b1;
        #1 directCheck("reset_bus", 4'd0, 1'b0, 1'b0, 4'd0);
        out_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;

        //            name           cnt jmp jc         cy zf bus   oe hlt  pc    hl wr
        applyStimulus("count1",      1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd1, 0, 0);
        applyStimulus("count2",      1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd2, 0, 0);
        applyStimulus("count3",      1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd3, 0, 0);
        applyStimulus("bus_drive",   0, 0, JC_NEVER,  0, 0, 4'd0, 1, 0, 4'd3, 0, 0);

        applyStimulus("jump14",      0, 1, JC_ALWAYS, 0, 0, 4'd14,0, 0, 4'd14,0, 0);
        applyStimulus("count15",     1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd15,0, 0);
        applyStimulus("wrap_pulse",  1, 0, JC_NEVER,  0, 0, 4'd0, 1, 0, 4'd0, 0, 1);
        applyStimulus("wrap_clear",  0, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd0, 0, 0);
        applyStimulus("count_nowrap",1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd1, 0, 0);
        applyStimulus("jump15",      0, 1, JC_ALWAYS, 0, 0, 4'd15,0, 0, 4'd15,0, 0);
        applyStimulus("jump_to_0",   1, 1, JC_ALWAYS, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0);

        applyStimulus("jump5",       0, 1, JC_ALWAYS, 0, 0, 4'd5, 0, 0, 4'd5, 0, 0);
        applyStimulus("carry0_cnt",  1, 1, JC_CARRY,  0, 1, 4'd9, 0, 0, 4'd6, 0, 0);
        applyStimulus("jump5b",      0, 1, JC_ALWAYS, 0, 0, 4'd5, 0, 0, 4'd5, 0, 0);
        applyStimulus("carry1_jmp",  0, 1, JC_CARRY,  1, 0, 4'd9, 0, 0, 4'd9, 0, 0);
        applyStimulus("zero1_jmp",   0, 1, JC_ZERO,   0, 1, 4'd2, 0, 0, 4'd2, 0, 0);
        applyStimulus("never_jmp",   0, 1, JC_NEVER,  1, 1, 4'd12,0, 0, 4'd2, 0, 0);
        applyStimulus("zero0_hold",  0, 1, JC_ZERO,   1, 0, 4'd12,0, 0, 4'd2, 0, 0);
        applyStimulus("no_jump_en",  0, 0, JC_ALWAYS, 0, 0, 4'd12,0, 0, 4'd2, 0, 0);
        applyStimulus("jump_over_cnt",1,1, JC_ALWAYS, 0, 0, 4'd12,0, 0, 4'd12,0, 0);

        applyStimulus("jump7",       0, 1, JC_ALWAYS, 0, 0, 4'd7, 0, 0, 4'd7, 0, 0);
        applyStimulus("halt_prio",   1, 1, JC_ALWAYS, 0, 0, 4'd3, 0, 1, 4'd7, 1, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus("halt_lock", 1, 1, JC_ALWAYS, 1, 1, 4'd3, 0, 0, 4'd7, 1, 0);
        applyStimulus("halt_bus",    1, 0, JC_NEVER,  0, 0, 4'd0, 1, 1, 4'd7, 1, 0);
        applyStimulus("halt_sticky", 0, 0, JC_NEVER,  0, 0, 4'd0, 1, 0, 4'd7, 1, 0);

        applyStimulus("jump11_dead", 0, 1, JC_ALWAYS, 0, 0, 4'd11,0, 0, 4'd7, 1, 0);
        asyncResetPulse("async_rst1");
        applyStimulus("jump11",      0, 1, JC_ALWAYS, 0, 0, 4'd11,0, 0, 4'd11,0, 0);
        applyStimulus("halt11",      0, 0, JC_NEVER,  0, 0, 4'd0, 0, 1, 4'd11,1, 0);
        asyncResetPulse("async_rst2");
        applyStimulus("resume1",     1, 0, JC_NEVER,  0, 0, 4'd0, 1, 0, 4'd1, 0, 0);
        applyStimulus("resume2",     1, 0, JC_NEVER,  0, 0, 4'd0, 0, 0, 4'd2, 0, 0);

        for (int i = 0; i < 20 && scoreboard.size() > 0; i++)
            @(negedge clk);
        if (scoreboard.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", scoreboard.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
